// File: rtl/sevenseg_scan_if.sv
// rtl/sevenseg_scan_if.sv - display data inputs and multiplexed pin outputs of the 4-digit scanner
interface sevenseg_scan_if;
  logic [15:0] disp_data;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [7:0]  bright;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  modport master (
    output disp_data, dp_mask, blank_mask, bright,
    input  seg, dp, an, frame
  );

  modport slave (
    input  disp_data, dp_mask, blank_mask, bright,
    output seg, dp, an, frame
  );
endinterface

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - 4-digit multiplexed 7-segment scanner with PWM dimming; SEVENSEG_LZB_EN enables leading-zero blanking
module sevenseg_scan #(
  parameter int SCAN_DIV = 25000
) (
  input  logic          clk,
  input  logic          rst_n,
  sevenseg_scan_if.slave bus
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] presc;
  logic [1:0]  idx;
  logic [7:0]  pwm_cnt;
  logic [15:0] data_sh;
  logic [3:0]  dp_sh;
  logic [3:0]  blank_sh;
  logic [7:0]  bright_sh;
  logic        frame_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_q;

  logic        slot_tick;
  logic        snap;
  logic [3:0]  digit;
  logic [6:0]  seg_dec;
  logic [3:0]  sup;
  logic        dark;
  logic        pwm_on;

  assign slot_tick = (presc == PRESC_MAX);
  assign snap      = slot_tick && (idx == 2'd3);

  // Slot prescaler and digit index: one digit slot every SCAN_DIV clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_tick) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Free-running PWM phase counter, wraps 255 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Snapshot inputs at the end of digit 3 so a whole frame shows one consistent value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sh   <= '0;
      dp_sh     <= '0;
      blank_sh  <= '0;
      bright_sh <= '0;
      frame_q   <= 1'b0;
    end else begin
      frame_q <= snap;
      if (snap) begin
        data_sh   <= bus.disp_data;
        dp_sh     <= bus.dp_mask;
        blank_sh  <= bus.blank_mask;
        bright_sh <= bus.bright;
      end
    end
  end

  // Select the nibble of the digit currently being scanned
  always_comb begin
    digit = 4'h0;
    case (idx)
      2'd0: digit = data_sh[3:0];
      2'd1: digit = data_sh[7:4];
      2'd2: digit = data_sh[11:8];
      2'd3: digit = data_sh[15:12];
      default: digit = 4'h0;
    endcase
  end

  // Hex to active-low {g,f,e,d,c,b,a}
  always_comb begin
    seg_dec = 7'h7F;
    case (digit)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      4'hF: seg_dec = 7'b0001110;
      default: seg_dec = 7'h7F;
    endcase
  end

  // Leading-zero suppression chain; a lit decimal point stops suppression at that digit
  always_comb begin
    sup = 4'b0000;
`ifdef SEVENSEG_LZB_EN
    sup[3] = (data_sh[15:12] == 4'h0) && !dp_sh[3];
    sup[2] = sup[3] && (data_sh[11:8] == 4'h0) && !dp_sh[2];
    sup[1] = sup[2] && (data_sh[7:4] == 4'h0) && !dp_sh[1];
`endif
  end

  assign dark   = blank_sh[idx] | sup[idx];
  assign pwm_on = (bright_sh == 8'hFF) || (pwm_cnt < bright_sh);

  // Registered pin drivers; segments keep the digit pattern while PWM holds the anode off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= (pwm_on && !dark) ? ~(4'b0001 << idx) : 4'hF;
      seg_q <= dark ? 7'h7F : seg_dec;
      dp_q  <= dark ? 1'b1 : ~dp_sh[idx];
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb/tb_sevenseg_scan.sv - directed bench for sevenseg_scan at SCAN_DIV=4
module tb_sevenseg_scan;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG2 = 7'b0100100;
  localparam logic [6:0] SEG5 = 7'b0010010;
  localparam logic [6:0] SEGA = 7'b0001000;
  localparam logic [6:0] SEGF = 7'b0001110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  sevenseg_scan_if dif ();

  sevenseg_scan #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame();
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dif.frame && cyc < 100);
    check_eq("frame_seen", {31'd0, dif.frame}, 32'd1);
  endtask

  // Called at the negedge where frame is high; checks the 16 following cycles, 4 per digit
  task automatic check_scan(input string tag, input logic [15:0] an_e,
                            input logic [27:0] seg_e, input logic [3:0] dp_e);
    for (int k = 1; k <= 16; k++) begin
      int i;
      @(negedge clk);
      i = (k - 1) / 4;
      check_eq($sformatf("%s_an_k%0d", tag, k), {28'd0, dif.an}, {28'd0, an_e[i*4 +: 4]});
      check_eq($sformatf("%s_seg_k%0d", tag, k), {25'd0, dif.seg}, {25'd0, seg_e[i*7 +: 7]});
      check_eq($sformatf("%s_dp_k%0d", tag, k), {31'd0, dif.dp}, {31'd0, dp_e[i]});
    end
  endtask

  // Release reset at a negedge; frame must appear on cycle 16 with all anodes dark before it
  task automatic release_and_check(input string tag);
    int cyc;
    int lit;
    cyc = 0;
    lit = 0;
    rst_n = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (dif.an !== 4'hF) lit++;
    end while (!dif.frame && cyc < 40);
    check_eq({tag, "_frame_cycle"}, cyc, 32'd16);
    check_eq({tag, "_dark_before_frame"}, lit, 32'd0);
  endtask

  initial begin
    int lit;
    int multi;

    dif.disp_data  = 16'h12AF;
    dif.dp_mask    = 4'h0;
    dif.blank_mask = 4'h0;
    dif.bright     = 8'hFF;

    repeat (3) @(negedge clk);
    check_eq("rst_an", {28'd0, dif.an}, 32'hF);
    check_eq("rst_seg", {25'd0, dif.seg}, 32'h7F);
    check_eq("rst_dp", {31'd0, dif.dp}, 32'd1);
    check_eq("rst_frame", {31'd0, dif.frame}, 32'd0);

    release_and_check("rel");
    check_scan("hex", {4'h7, 4'hB, 4'hD, 4'hE}, {SEG1, SEG2, SEGA, SEGF}, 4'hF);

    // PWM duty at bright=0x40, all digits 8
    dif.disp_data = 16'h8888;
    dif.bright    = 8'h40;
    wait_frame();
    lit = 0;
    multi = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (dif.an !== 4'hF) lit++;
      if ($countones(~dif.an) > 1) multi++;
    end
    check_eq("pwm40_lit", lit, 32'd64);
    check_eq("pwm40_onehot", multi, 32'd0);

    dif.bright = 8'h00;
    wait_frame();
    lit = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (dif.an !== 4'hF) lit++;
    end
    check_eq("pwm0_lit", lit, 32'd0);

    // Mid-frame data change is held off until the next snapshot
    dif.disp_data = 16'h1111;
    dif.bright    = 8'hFF;
    wait_frame();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 6) dif.disp_data = 16'h2222;
      check_eq($sformatf("hold_seg_k%0d", k), {25'd0, dif.seg}, {25'd0, SEG1});
    end
    check_eq("hold_frame", {31'd0, dif.frame}, 32'd1);
    check_scan("new", {4'h7, 4'hB, 4'hD, 4'hE}, {SEG2, SEG2, SEG2, SEG2}, 4'hF);

    // Blank mask darkens digit 1 only
    dif.disp_data  = 16'h12AF;
    dif.blank_mask = 4'b0010;
    wait_frame();
    check_scan("blank", {4'h7, 4'hB, 4'hF, 4'hE}, {SEG1, SEG2, 7'h7F, SEGF}, 4'hF);

    // Leading zeros with a decimal point on digit 2
    dif.disp_data  = 16'h0005;
    dif.dp_mask    = 4'b0100;
    dif.blank_mask = 4'b0000;
    wait_frame();
`ifdef SEVENSEG_LZB_EN
    check_scan("lzb", {4'hF, 4'hB, 4'hD, 4'hE}, {7'h7F, SEG0, SEG0, SEG5}, 4'b1011);
`else
    check_scan("lz", {4'h7, 4'hB, 4'hD, 4'hE}, {SEG0, SEG0, SEG0, SEG5}, 4'b1011);
`endif

    // Asynchronous reset while digit 2 is lit
    dif.disp_data = 16'h12AF;
    dif.dp_mask   = 4'b0000;
    wait_frame();
    repeat (9) @(negedge clk);
    check_eq("pre_rst_an", {28'd0, dif.an}, 32'hB);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_an", {28'd0, dif.an}, 32'hF);
    check_eq("async_rst_seg", {25'd0, dif.seg}, 32'h7F);
    check_eq("async_rst_dp", {31'd0, dif.dp}, 32'd1);
    check_eq("async_rst_frame", {31'd0, dif.frame}, 32'd0);
    repeat (2) @(negedge clk);
    release_and_check("rel2");
    @(negedge clk);
    check_eq("rel2_first_an", {28'd0, dif.an}, 32'hE);
    check_eq("rel2_first_seg", {25'd0, dif.seg}, {25'd0, SEGF});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 25000, meaning clocks per digit slot (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1, meaning the system clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 The block SHALL have port disp_data, input, 16, meaning four hex digits; digit i is bits [4i+3:4i] and digit 0 is rightmost.
REQ-005 The block SHALL have port dp_mask, input, 4, meaning bit i lights the decimal point of digit i.
REQ-006 The block SHALL have port blank_mask, input, 4, meaning bit i forces digit i dark.
REQ-007 The block SHALL have port bright, input, 8, meaning the PWM brightness duty.
REQ-008 The block SHALL have port seg, output, 7, meaning cathodes {g,f,e,d,c,b,a}, active low.
REQ-009 The block SHALL have port dp, output, 1, meaning the decimal point cathode, active low.
REQ-010 The block SHALL have port an, output, 4, meaning the digit anodes, active low, one-hot-low when lit.
REQ-011 The block SHALL have port frame, output, 1, meaning a one-clock pulse when a new input snapshot is taken.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; slot tick SHALL be asserted when the prescaler equals SCAN_DIV-1.
REQ-013 Digit index SHALL advance 0->1->2->3->0 on each slot tick.
REQ-014 On a slot tick with digit index 3, disp_data, dp_mask, blank_mask and bright SHALL be captured into shadow registers, and frame SHALL pulse high in the following cycle; input changes mid-frame SHALL NOT affect the display until the next snapshot.
REQ-015 The 8-bit PWM counter SHALL free-run, wrapping 255->0; the anode is enabled when pwm_cnt < bright_shadow, or always when bright_shadow = 8'hFF; bright_shadow = 0 keeps all anodes high.
REQ-016 Hex decode SHALL be standard, including 0=7'b1000000, 8=7'b0000000, A=7'b0001000, F=7'b0001110; dp = ~dp_mask_shadow[idx].
REQ-017 A digit with blank_mask_shadow[idx]=1 SHALL drive an[idx]=1, seg=7'h7F and dp=1.
REQ-018 an, seg and dp SHALL be registered, with one clock of latency from index/PWM state to pins; at most one an bit SHALL be low at any time.
REQ-019 While PWM is off, seg/dp SHALL still present the current digit's pattern (ghost-free because an is high).

Reset
REQ-020 While rst_n=0, outputs SHALL be an=4'hF, seg=7'h7F, dp=1 and frame=0; prescaler, digit index, PWM counter and all shadow registers SHALL be 0.
REQ-021 After rst_n deasserts, the first snapshot SHALL occur after 4*SCAN_DIV clocks, and the display SHALL remain dark until then (bright_shadow=0).
REQ-022 Reset asserted mid-frame SHALL take effect immediately and asynchronously, with no partial-digit output afterwards.

Configuration
REQ-023 With SEVENSEG_LZB_EN defined, digits 3..1 SHALL be blanked when the digit and all higher digits are zero and the digit's dp_mask bit is 0; digit 0 is never suppressed.
REQ-024 Without SEVENSEG_LZB_EN, all digits not masked by blank_mask SHALL be displayed, including leading zeros.

Verification (bench SCAN_DIV=4)
REQ-025 Hold rst_n=0, then release -> an=F, seg=7F, dp=1 until the first frame pulse at clock 16; no an low before that.
REQ-026 disp_data=16'h12AF, bright=FF, masks 0 -> an cycles E,D,B,7 every 4 clocks, with seg 0001110, 0001000, 0100100, 1111001 respectively.
REQ-027 bright=8'h40, steady digit -> the selected an bit is low exactly 64 of every 256 clocks; bright=0 -> an stays F.
REQ-028 Change disp_data from 1111 to 2222 during digit 1 -> no 2 appears before the next frame pulse, then all digits show 2.
REQ-029 disp_data=16'h0005, dp_mask=4'b0100: with SEVENSEG_LZB_EN, digit 3 is dark and digits 2,1,0 show 0.,0,5; without the macro, all four digits are lit.
REQ-030 Assert rst_n=0 during digit 2 at bright=FF -> same cycle an=F, seg=7F; after release the index restarts at 0.
